axi_master_arbiter: RTL

- Shares the single Axi4_Lite_Master command interface (cmd/addr/write_data/start/done/status/read_data) between NUM_REQ requesters, e.g. the UART frame parser and the on-chip self-test/config sequencer.
- Round-robin arbitration; one transaction outstanding at a time.
- Converts each requester's valid/ready request into a one-cycle master start pulse and returns a one-cycle response to the granted requester.
- Sits between the requesters and Axi4_Lite_Master; Register_Block stays behind the master unchanged.

---
 rtl/axi_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 49 ++++
 rtl/axi_master_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI4-Lite master arbiter.
//   arb_state_e            : arbiter FSM states
//   STATUS_OK              : status value for a clean transaction
//   DEFAULT_TIMEOUT_STATUS : default status reported when the master never answers
//   MAX_REQ / IDX_W        : largest supported requester count and its index width
package axi_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } arb_state_e;

  localparam logic [7:0]  STATUS_OK              = 8'h00;
  localparam logic [7:0]  DEFAULT_TIMEOUT_STATUS = 8'hFE;
  localparam int unsigned MAX_REQ                = 8;
  localparam int unsigned IDX_W                  = $clog2(MAX_REQ);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick over a request vector.
//   clk, rst   : clock, synchronous active-high reset (pointer returns to 0)
//   req        : request vector, one bit per requester
//   advance    : a grant was accepted this cycle; move the pointer past the winner
//   grant      : one-hot winner (combinational)
//   grant_idx  : index of the winner (combinational)
//   any        : at least one request present
module rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  logic [IDX_W-1:0] ptr_q;

  // First requester at or above the pointer, wrapping around.
  always_comb begin
    int unsigned k;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    k         = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      k = (32'(ptr_q) + off) % NUM_REQ;
      if (!any && req[k]) begin
        any       = 1'b1;
        grant_idx = IDX_W'(k);
        grant[k]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance && any) begin
      ptr_q <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/axi_master_arbiter.sv
// Shares one AXI4-Lite master command interface between NUM_REQ requesters.
// Round-robin grant, one transaction outstanding, one-cycle start pulse to the master
// and one-cycle response strobe back to the granted requester.
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid/ready               : per-requester handshake (ready only in idle, winner only)
//   req_cmd/addr/wdata            : flattened per-requester command fields
//   rsp_valid                     : one-cycle response strobe to the granted requester
//   rsp_status/rdata/count        : response payload, held until the next response
//   mst_cmd/addr/wdata/start      : command towards the master
//   mst_done/status/rdata/rdata_count : completion from the master
//   busy                          : a transaction is in progress
//   grant_id                      : current or last granted requester
//   timeout_flag / clear_flags    : sticky timeout indicator and its clear
module axi_master_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  TIMEOUT_STATUS = DEFAULT_TIMEOUT_STATUS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*8-1:0]  req_cmd,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [7:0]            rsp_status,
  output logic [31:0]           rsp_rdata,
  output logic [5:0]            rsp_count,
  output logic [7:0]            mst_cmd,
  output logic [31:0]           mst_addr,
  output logic [31:0]           mst_wdata,
  output logic                  mst_start,
  input  logic                  mst_done,
  input  logic [7:0]            mst_status,
  input  logic [31:0]           mst_rdata,
  input  logic [5:0]            mst_rdata_count,
  output logic                  busy,
  output logic [IDX_W-1:0]      grant_id,
  output logic                  timeout_flag,
  input  logic                  clear_flags
);

  localparam int unsigned   CntW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  arb_state_e         state_q;
  logic [CntW-1:0]    wait_cnt_q;
  logic [NUM_REQ-1:0] win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic               handshake;
  logic [7:0]         sel_cmd;
  logic [31:0]        sel_addr;
  logic [31:0]        sel_wdata;

  assign handshake = (state_q == StIdle) && win_any;
  assign req_ready = handshake ? win_onehot : '0;
  assign busy      = (state_q != StIdle);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (handshake),
    .grant     (win_onehot),
    .grant_idx (win_idx),
    .any       (win_any)
  );

  // Mux the winner's command fields.
  always_comb begin
    sel_cmd   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_onehot[i]) begin
        sel_cmd   = req_cmd[i*8 +: 8];
        sel_addr  = req_addr[i*32 +: 32];
        sel_wdata = req_wdata[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      wait_cnt_q   <= '0;
      mst_cmd      <= '0;
      mst_addr     <= '0;
      mst_wdata    <= '0;
      mst_start    <= 1'b0;
      rsp_valid    <= '0;
      rsp_status   <= STATUS_OK;
      rsp_rdata    <= '0;
      rsp_count    <= '0;
      grant_id     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      mst_start <= 1'b0;
      rsp_valid <= '0;
      // A timeout in the same cycle overrides this clear further down.
      if (clear_flags) begin
        timeout_flag <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (win_any) begin
            mst_cmd   <= sel_cmd;
            mst_addr  <= sel_addr;
            mst_wdata <= sel_wdata;
            grant_id  <= win_idx;
            mst_start <= 1'b1;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          wait_cnt_q <= '0;
          state_q    <= StWait;
        end
        StWait: begin
          if (mst_done) begin
            rsp_status <= mst_status;
            rsp_rdata  <= mst_rdata;
            rsp_count  <= mst_rdata_count;
            rsp_valid  <= NUM_REQ'(1) << grant_id;
            state_q    <= StResp;
          end else if (wait_cnt_q == CntLast) begin
            rsp_status   <= TIMEOUT_STATUS;
            rsp_rdata    <= '0;
            rsp_count    <= '0;
            rsp_valid    <= NUM_REQ'(1) << grant_id;
            timeout_flag <= 1'b1;
            state_q      <= StResp;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
